// File: rtl/bram_sim_pkg.sv
// Shared types and helpers for the behavioural block-RAM model.
package bram_sim_pkg;

  typedef enum logic [1:0] {
    INIT_ZERO,
    INIT_INDEX,
    INIT_CONST
  } init_mode_e;

  localparam int unsigned MAX_RD_LAT = 4;

  // Never returns 0, so a single-word memory still gets a 1-bit index.
  function automatic int unsigned clog2_safe(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bram_model_sim_if.sv
// BRAM port bundle between a conv engine (master) and the memory model (slave).
interface bram_model_sim_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ERR_W  = 16
);
  logic                  bram_en;
  logic [ADDR_W-1:0]     bram_addr;
  logic [DATA_W-1:0]     bram_wrdata;
  logic [DATA_W/8-1:0]   bram_we;
  logic [DATA_W-1:0]     bram_rddata;
  logic                  bram_rdvalid;
  logic                  oob_flag;
  logic [ERR_W-1:0]      err_count;

  modport master (
    output bram_en, bram_addr, bram_wrdata, bram_we,
    input  bram_rddata, bram_rdvalid, oob_flag, err_count
  );

  modport slave (
    input  bram_en, bram_addr, bram_wrdata, bram_we,
    output bram_rddata, bram_rdvalid, oob_flag, err_count
  );
endinterface

// File: rtl/bram_rd_pipe.sv
// Read-result delay line; each stage's data only advances with its valid bit,
// so the last stage holds the most recent result between strobes.
module bram_rd_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STAGES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic [STAGES-1:0] r_valid;
  logic [DATA_W-1:0] r_data [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      for (int unsigned s = 0; s < STAGES; s++) begin
        r_data[s] <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      if (i_valid) begin
        r_data[0] <= i_data;
      end
      for (int unsigned s = 1; s < STAGES; s++) begin
        r_valid[s] <= r_valid[s-1];
        if (r_valid[s-1]) begin
          r_data[s] <= r_data[s-1];
        end
      end
    end
  end

  assign o_valid = r_valid[STAGES-1];
  assign o_data  = r_data[STAGES-1];

endmodule

// File: rtl/bram_model_sim.sv
// Configurable behavioural block-RAM for conv engine benches: byte enables,
// pipelined read latency, read-during-write mode and out-of-range detection.
module bram_model_sim
  import bram_sim_pkg::*;
#(
  parameter int unsigned      DATA_W     = 32,
  parameter int unsigned      DEPTH      = 48,
  parameter int unsigned      ADDR_W     = 32,
  parameter int unsigned      RD_LAT     = 1,
  parameter int unsigned      READ_FIRST = 1,
  parameter int unsigned      INIT_MODE  = 1,
  parameter logic [DATA_W-1:0] INIT_VAL  = '0,
  parameter int unsigned      ERR_W      = 16
) (
  input logic            clk,
  input logic            reset,
  bram_model_sim_if.slave bus
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned LSB   = $clog2(NB);
  localparam int unsigned IDX_W = clog2_safe(DEPTH);
  localparam int unsigned MEM_W = DEPTH * DATA_W;

  if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_chk_lat
    $fatal(1, "bram_model_sim: RD_LAT must be within 1..%0d", MAX_RD_LAT);
  end
  if (DATA_W % 8 != 0) begin : g_chk_dw
    $fatal(1, "bram_model_sim: DATA_W must be a multiple of 8");
  end
  if (DEPTH < 1) begin : g_chk_depth
    $fatal(1, "bram_model_sim: DEPTH must be at least 1");
  end
  if (INIT_MODE > 2) begin : g_chk_init
    $fatal(1, "bram_model_sim: INIT_MODE must be 0, 1 or 2");
  end

  function automatic logic [MEM_W-1:0] f_init_image();
    logic [MEM_W-1:0] img;
    img = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      case (init_mode_e'(INIT_MODE))
        INIT_INDEX: img[i*DATA_W +: DATA_W] = DATA_W'(i + 1);
        INIT_CONST: img[i*DATA_W +: DATA_W] = INIT_VAL;
        default:    img[i*DATA_W +: DATA_W] = '0;
      endcase
    end
    return img;
  endfunction

  // Loaded once at time zero; reset intentionally leaves the contents alone.
  logic [MEM_W-1:0] r_mem = f_init_image();

  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  w_idx_safe;
  logic              w_oob;
  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] w_rd_word;

  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_oob_flag;
  logic [ERR_W-1:0]  r_err_count;

  logic              w_pipe_valid;
  logic [DATA_W-1:0] w_pipe_data;

  assign w_idx = bus.bram_addr[LSB +: IDX_W];
  // Any address bit above the index field also makes the access out of range.
  assign w_oob = (|(bus.bram_addr >> (LSB + IDX_W))) || (32'(w_idx) >= DEPTH);

  always_comb begin
    w_idx_safe = w_oob ? '0 : w_idx;
    w_old      = r_mem[32'(w_idx_safe)*DATA_W +: DATA_W];
    w_merged   = w_old;
    for (int unsigned b = 0; b < NB; b++) begin
      if (bus.bram_we[b]) begin
        w_merged[8*b +: 8] = bus.bram_wrdata[8*b +: 8];
      end
    end
    if (w_oob) begin
      w_rd_word = '0;
    end else if (READ_FIRST != 0) begin
      w_rd_word = w_old;
    end else begin
      w_rd_word = w_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.bram_en && !w_oob) begin
      r_mem[32'(w_idx_safe)*DATA_W +: DATA_W] <= w_merged;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_oob_flag  <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_rd_valid <= bus.bram_en;
      if (bus.bram_en) begin
        r_rd_data <= w_rd_word;
      end
      if (bus.bram_en && w_oob) begin
        r_oob_flag <= 1'b1;
        if (r_err_count != '1) begin
          r_err_count <= r_err_count + ERR_W'(1);
        end
      end
    end
  end

  if (RD_LAT > 1) begin : g_pipe
    bram_rd_pipe #(
      .DATA_W (DATA_W),
      .STAGES (RD_LAT - 1)
    ) u_rd_pipe (
      .clk     (clk),
      .reset   (reset),
      .i_valid (r_rd_valid),
      .i_data  (r_rd_data),
      .o_valid (w_pipe_valid),
      .o_data  (w_pipe_data)
    );
  end else begin : g_no_pipe
    assign w_pipe_valid = r_rd_valid;
    assign w_pipe_data  = r_rd_data;
  end

  assign bus.bram_rddata  = w_pipe_data;
  assign bus.bram_rdvalid = w_pipe_valid;
  assign bus.oob_flag     = r_oob_flag;
  assign bus.err_count    = r_err_count;

endmodule

// File: tb/tb_bram_model_sim.sv
// Drives a latency-1 read-first model and a latency-3 write-first model with
// identical traffic and compares both against a word-array reference.
module tb_bram_model_sim;

  localparam int unsigned DEPTH = 48;

  logic        clk;
  logic        reset;
  logic        en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  we;

  bram_model_sim_if #(.DATA_W(32), .ADDR_W(32), .ERR_W(16)) bus_a ();
  bram_model_sim_if #(.DATA_W(32), .ADDR_W(32), .ERR_W(2))  bus_b ();

  assign bus_a.bram_en     = en;
  assign bus_a.bram_addr   = addr;
  assign bus_a.bram_wrdata = wdata;
  assign bus_a.bram_we     = we;
  assign bus_b.bram_en     = en;
  assign bus_b.bram_addr   = addr;
  assign bus_b.bram_wrdata = wdata;
  assign bus_b.bram_we     = we;

  bram_model_sim #(
    .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .RD_LAT(1), .READ_FIRST(1),
    .INIT_MODE(1), .INIT_VAL(32'h0), .ERR_W(16)
  ) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  bram_model_sim #(
    .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .RD_LAT(3), .READ_FIRST(0),
    .INIT_MODE(1), .INIT_VAL(32'h0), .ERR_W(2)
  ) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  rd_t         q_a[$];
  rd_t         q_b[$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] last_a, last_b;
  logic        flag_m;
  int          cnt_a, cnt_b;
  int          total, bad, cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q_a.delete();
    q_b.delete();
    last_a = '0;
    last_b = '0;
    flag_m = 1'b0;
    cnt_a  = 0;
    cnt_b  = 0;
  endtask

  task automatic model_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    logic        ok;
    logic [31:0] old_w, new_w;
    int          idx;
    ok    = (a / 32'd4) < DEPTH;
    idx   = ok ? int'(a / 32'd4) : 0;
    old_w = ok ? mem_m[idx] : 32'h0;
    new_w = old_w;
    for (int b = 0; b < 4; b++) begin
      if (w[b]) new_w[8*b +: 8] = d[8*b +: 8];
    end
    if (ok) begin
      mem_m[idx] = new_w;
    end else begin
      flag_m = 1'b1;
      cnt_a  = (cnt_a < 65535) ? cnt_a + 1 : 65535;
      cnt_b  = (cnt_b < 3) ? cnt_b + 1 : 3;
    end
    q_a.push_back('{due: cyc,     data: ok ? old_w : 32'h0});
    q_b.push_back('{due: cyc + 2, data: ok ? new_w : 32'h0});
  endtask

  task automatic check_all();
    logic exp_va, exp_vb;
    rd_t  r;
    exp_va = 1'b0;
    exp_vb = 1'b0;
    if (q_a.size() > 0 && q_a[0].due == cyc) begin
      r = q_a.pop_front();
      last_a = r.data;
      exp_va = 1'b1;
    end
    if (q_b.size() > 0 && q_b[0].due == cyc) begin
      r = q_b.pop_front();
      last_b = r.data;
      exp_vb = 1'b1;
    end
    chk("a_rdvalid", 32'(bus_a.bram_rdvalid), 32'(exp_va));
    chk("a_rddata",  bus_a.bram_rddata, last_a);
    chk("a_oob",     32'(bus_a.oob_flag), 32'(flag_m));
    chk("a_errcnt",  32'(bus_a.err_count), cnt_a);
    chk("b_rdvalid", 32'(bus_b.bram_rdvalid), 32'(exp_vb));
    chk("b_rddata",  bus_b.bram_rddata, last_b);
    chk("b_oob",     32'(bus_b.oob_flag), 32'(flag_m));
    chk("b_errcnt",  32'(bus_b.err_count), cnt_b);
  endtask

  task automatic step(input logic e, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] w);
    en    = e;
    addr  = a;
    wdata = d;
    we    = w;
    @(posedge clk);
    cyc++;
    if (e && !reset) model_access(a, d, w);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    logic        r_en;
    logic [31:0] r_addr;
    logic [3:0]  r_we;
    int unsigned sel;

    total = 0;
    bad   = 0;
    cyc   = 0;
    reset = 1'b1;
    en    = 1'b0;
    addr  = '0;
    wdata = '0;
    we    = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'(i + 1);
    model_clear();

    idle(2);
    reset = 1'b0;

    // Index-pattern reads, latency 1 on A.
    step(1'b1, 32'h0, 32'h0, 4'h0);
    chk("t1_word0", bus_a.bram_rddata, 32'd1);
    step(1'b1, 32'h4, 32'h0, 4'h0);
    chk("t1_word1", bus_a.bram_rddata, 32'd2);
    step(1'b1, 32'hBC, 32'h0, 4'h0);
    chk("t1_word47", bus_a.bram_rddata, 32'd48);

    // Back-to-back reads of words 0..5 through B's three-cycle pipeline.
    for (int w = 0; w < 6; w++) step(1'b1, 32'(4 * w), 32'h0, 4'h0);
    idle(3);

    // Byte-enabled write then read-back.
    step(1'b1, 32'hC, 32'hAABBCCDD, 4'b0101);
    step(1'b1, 32'hC, 32'h0, 4'h0);
    chk("t2_merge", bus_a.bram_rddata, 32'h00BB00DD);
    idle(2);

    // Read-during-write on word 4.
    step(1'b1, 32'h10, 32'h12345678, 4'hF);
    chk("t4_rd_first", bus_a.bram_rddata, 32'd5);
    step(1'b1, 32'h10, 32'h0, 4'h0);
    chk("t4_follow_a", bus_a.bram_rddata, 32'h12345678);
    step(1'b0, 32'h0, 32'h0, 4'h0);
    chk("t4_wr_first", bus_b.bram_rddata, 32'h12345678);
    idle(2);

    // Out-of-range accesses and error counter saturation.
    step(1'b1, 32'hC0, 32'hDEADBEEF, 4'hF);
    step(1'b1, 32'hC0, 32'h0, 4'h0);
    chk("t5_oob_data", bus_a.bram_rddata, 32'h0);
    chk("t5_oob_cnt", 32'(bus_a.err_count), 32'd2);
    step(1'b1, 32'hBC, 32'h0, 4'h0);
    chk("t5_word47", bus_a.bram_rddata, 32'd48);
    step(1'b0, 32'hC0, 32'h55555555, 4'hF);
    step(1'b1, 32'h100, 32'h0, 4'h0);
    step(1'b1, 32'h8000_0004, 32'h0, 4'h0);
    step(1'b1, 32'hC4, 32'h0, 4'h0);
    idle(3);
    chk("t5_sat", 32'(bus_b.err_count), 32'd3);

    // Reset with reads in flight; memory survives.
    step(1'b1, 32'h28, 32'hCAFEF00D, 4'hF);
    idle(3);
    step(1'b1, 32'h0, 32'h0, 4'h0);
    step(1'b1, 32'h4, 32'h0, 4'h0);
    reset = 1'b1;
    #1;
    model_clear();
    check_all();
    step(1'b0, 32'h0, 32'h0, 4'h0);
    reset = 1'b0;
    idle(3);
    step(1'b1, 32'h28, 32'h0, 4'h0);
    chk("t6_mem_kept", bus_a.bram_rddata, 32'hCAFEF00D);
    idle(3);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      r_en = ($urandom_range(0, 3) != 0);
      sel  = $urandom_range(0, 9);
      if (sel == 0) begin
        r_addr = $urandom();
      end else if (sel == 1) begin
        r_addr = 32'(4 * $urandom_range(48, 63)) + 32'($urandom_range(0, 3));
      end else begin
        r_addr = 32'($urandom_range(0, 191));
      end
      r_we = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      step(r_en, r_addr, $urandom(), r_we);
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
